// File: rtl/relu_pipe_if.sv
// Streaming interface of relu_pipe: input beat with its activation config and the result beat.
// The slave modport is the unit's view. The master modport is the producer/consumer view.
interface relu_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 8,
  parameter int SHIFT_W = 3
);
  logic [1:0]             mode;
  logic [SHIFT_W-1:0]     shift;
  logic [WIDTH-1:0]       clip_val;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output mode, shift, clip_val, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode, shift, clip_val, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/relu_pipe.sv
// Two-stage multi-lane activation unit (bypass / ReLU / leaky ReLU / clipped ReLU) with valid/ready flow.
// Optional macro RELU_PIPE_ZERO_CNT_EN adds a saturating count of negative lanes zeroed by ReLU/clip.
module relu_pipe #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  relu_pipe_if.slave  bus,
  output logic        busy
`ifdef RELU_PIPE_ZERO_CNT_EN
  ,
  output logic [31:0] zero_cnt,
  input  logic        zero_cnt_clr
`endif
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_e;

  localparam int DATA_W = LANES * WIDTH;

  logic                      w_adv;
  logic                      r_s1_valid;
  logic [DATA_W-1:0]         r_s1_data;
  mode_e                     r_s1_mode;
  logic [SHIFT_W-1:0]        r_s1_shift;
  logic signed [WIDTH-1:0]   r_s1_clip;
  logic signed [WIDTH-1:0]   w_ceil;
  logic [DATA_W-1:0]         w_result;
  logic                      r_s2_valid;
  logic [DATA_W-1:0]         r_s2_data;

  // A single enable moves the whole pipe, so a stalled output freezes both stages.
  assign w_adv         = ~r_s2_valid | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign busy          = r_s1_valid | r_s2_valid;

  // NOTE: state registers use non-blocking (<=) so S2 sees S1's pre-edge contents, not the value loaded this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_BYPASS;
      r_s1_shift <= '0;
      r_s1_clip  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s1_data  <= bus.in_data;
      r_s1_mode  <= mode_e'(bus.mode);
      r_s1_shift <= bus.shift;
      r_s1_clip  <= bus.clip_val;
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_result;
    end
  end

  assign w_ceil = (r_s1_clip < 0) ? '0 : r_s1_clip;

  always_comb begin : lane_fn
    logic signed [WIDTH-1:0] w_x;
    // NOTE: every always_comb output gets a default before the loop so no path can infer a latch.
    w_result = '0;
    w_x      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_x = r_s1_data[i*WIDTH +: WIDTH];
      unique case (r_s1_mode)
        MODE_RELU:  w_result[i*WIDTH +: WIDTH] = (w_x < 0) ? '0 : w_x;
        MODE_LEAKY: w_result[i*WIDTH +: WIDTH] = (w_x < 0) ? (w_x >>> r_s1_shift) : w_x;
        MODE_CLIP:  w_result[i*WIDTH +: WIDTH] = (w_x < 0) ? '0 : ((w_x > w_ceil) ? w_ceil : w_x);
        default:    w_result[i*WIDTH +: WIDTH] = w_x;
      endcase
    end
  end

`ifdef RELU_PIPE_ZERO_CNT_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] w_zero_num;
  logic [CNT_W-1:0] r_s2_zeros;
  logic [31:0]      r_zero_cnt;
  logic [32:0]      w_cnt_sum;
  logic             w_out_xfer;

  // Only ReLU and clip map a negative input to exactly 0; leaky never reaches 0 from below.
  always_comb begin
    w_zero_num = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((r_s1_mode == MODE_RELU || r_s1_mode == MODE_CLIP) && r_s1_data[i*WIDTH + WIDTH - 1])
        w_zero_num = w_zero_num + CNT_W'(1);
    end
  end

  assign w_out_xfer = r_s2_valid & bus.out_ready;
  assign w_cnt_sum  = {1'b0, r_zero_cnt} + 33'(r_s2_zeros);
  assign zero_cnt   = r_zero_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_zeros <= '0;
      r_zero_cnt <= '0;
    end else begin
      if (w_adv)
        r_s2_zeros <= w_zero_num;
      if (zero_cnt_clr)
        r_zero_cnt <= '0;
      else if (w_out_xfer)
        r_zero_cnt <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_relu_pipe.sv
// Scoreboard bench for relu_pipe: a driver pushes model results, a monitor pops them on output transfers.
// Build with RELU_PIPE_ZERO_CNT_EN defined to also exercise the zero-lane counter.
module tb_relu_pipe;
  localparam int WIDTH   = 8;
  localparam int LANES   = 8;
  localparam int SHIFT_W = 3;

  typedef struct {
    logic [63:0] data;
    int          zeros;
  } exp_t;

  logic clk;
  logic reset_n;
  logic busy;
`ifdef RELU_PIPE_ZERO_CNT_EN
  logic [31:0] zero_cnt;
  logic        zero_cnt_clr;
  longint      exp_cnt;
`endif

  relu_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .SHIFT_W(SHIFT_W)) bus ();

  relu_pipe #(.WIDTH(WIDTH), .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .busy         (busy)
`ifdef RELU_PIPE_ZERO_CNT_EN
    ,
    .zero_cnt     (zero_cnt),
    .zero_cnt_clr (zero_cnt_clr)
`endif
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   ready_ctl = 0;   // 0: always ready, 1: random backpressure, 2: held low

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference model: plain integer arithmetic on each lane.
  function automatic exp_t model(input logic [63:0] d, input int m, input int sh, input int cv);
    exp_t r;
    int   x, y, c, dv;
    logic [31:0] t;
    r.data  = '0;
    r.zeros = 0;
    c = (cv < 0) ? 0 : cv;
    for (int i = 0; i < LANES; i++) begin
      x = $signed(d[i*WIDTH +: WIDTH]);
      case (m)
        1: y = (x < 0) ? 0 : x;
        2: begin
          if (x < 0) begin
            dv = 1 << sh;
            y  = x / dv;
            if (y * dv != x) y = y - 1;   // floor for negatives
          end else begin
            y = x;
          end
        end
        3: y = (x < 0) ? 0 : ((x > c) ? c : x);
        default: y = x;
      endcase
      if ((m == 1 || m == 3) && x < 0) r.zeros++;
      t = y;
      r.data[i*WIDTH +: WIDTH] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] pack(input int v[8]);
    logic [63:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = v[i];
      r[i*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_beat();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom % 6)
        0:       r[i*8 +: 8] = 8'h80;
        1:       r[i*8 +: 8] = 8'h7f;
        2:       r[i*8 +: 8] = 8'hff;
        3:       r[i*8 +: 8] = 8'h00;
        default: r[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return r;
  endfunction

  // Driver: holds the beat until accepted, pushing the model result at the acceptance cycle.
  task automatic send(input logic [63:0] d, input int m, input int sh, input int cv);
    int   waited = 0;
    logic [31:0] t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    t = m;  bus.mode     = t[1:0];
    t = sh; bus.shift    = t[SHIFT_W-1:0];
    t = cv; bus.clip_val = t[WIDTH-1:0];
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(d, m, sh, cv));
        break;
      end
      waited++;
      if (waited > 200) begin
        timeout_fail("send_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) timeout_fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output-ready generator, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_ctl)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 4) != 0;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every output transfer with the scoreboard head and checks stall behaviour.
  logic [63:0] held_data;
  bit          held_v = 0;
  exp_t        e;
  always @(negedge clk) begin
    if (!reset_n) begin
      held_v = 0;
`ifdef RELU_PIPE_ZERO_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      if (held_v && bus.out_valid) check("hold_stable", bus.out_data, held_data);
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      held_v    = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      e.zeros   = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
        end
      end
`ifdef RELU_PIPE_ZERO_CNT_EN
      if (zero_cnt_clr) exp_cnt = 0;
      else if (bus.out_valid && bus.out_ready) begin
        exp_cnt = exp_cnt + e.zeros;
        if (exp_cnt > 64'hffff_ffff) exp_cnt = 64'hffff_ffff;
      end
`endif
    end
  end

  initial begin
    int v[8];
    int n;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = '0;
    bus.shift    = '0;
    bus.clip_val = '0;
`ifdef RELU_PIPE_ZERO_CNT_EN
    zero_cnt_clr = 1'b0;
`endif
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_data",  bus.out_data,       64'd0);
`ifdef RELU_PIPE_ZERO_CNT_EN
    check("rst_zero_cnt",  64'(zero_cnt),      64'd0);
`endif
    #24 reset_n = 1'b1;

    // ReLU vector with latency check
    @(posedge clk); #1;
    v = '{-128, -1, 0, 1, 5, 127, -7, 64};
    send(pack(v), 1, 0, 0);
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    check("lat_in_ready",     64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    check("relu_vec",         bus.out_data,       64'h4000_7f05_0100_0000);
    drain();

    // Leaky ReLU, shift 2 then shift 0
    v = '{-128, -1, -4, -5, 3, -100, 0, 127};
    send(pack(v), 2, 2, 0);
    send(pack(v), 2, 0, 0);
    // Clipped ReLU, positive then negative ceiling
    v = '{-3, 0, 5, 6, 7, 100, -128, 127};
    send(pack(v), 3, 0, 6);
    send(pack(v), 3, 0, -5);
    drain();

    // Stream of 10 beats with alternating mode and a 3-cycle mid-stream stall
    fork
      begin
        for (int i = 0; i < 10; i++) send(rand_beat(), i % 2, 0, 0);
      end
      begin
        repeat (5) @(posedge clk);
        ready_ctl = 2;
        repeat (3) @(posedge clk);
        ready_ctl = 0;
      end
    join
    drain();

    // Asynchronous reset while a beat is stalled at the output
    ready_ctl = 2;
    @(posedge clk); #1;
    send(rand_beat(), 0, 0, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_before_reset", 64'(bus.out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_busy",      64'(busy),          64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    check("arst_out_data",  bus.out_data,       64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    ready_ctl = 0;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_valid", 64'(bus.out_valid), 64'd0);
    check("post_reset_busy",  64'(busy),          64'd0);

`ifdef RELU_PIPE_ZERO_CNT_EN
    zero_cnt_clr = 1'b1;
    @(posedge clk); #1;
    zero_cnt_clr = 1'b0;
    v = '{-1, -128, -50, 0, 1, 127, 3, 9};
    for (int i = 0; i < 4; i++) send(pack(v), 1, 0, 0);
    drain();
    check("zero_cnt_12", 64'(zero_cnt), 64'd12);
    send(pack(v), 1, 0, 0);
    @(posedge clk); #1;
    check("clr_xfer_valid", 64'(bus.out_valid), 64'd1);
    zero_cnt_clr = 1'b1;
    @(posedge clk); #1;
    zero_cnt_clr = 1'b0;
    check("zero_cnt_clr_priority", 64'(zero_cnt), 64'd0);
    drain();
`endif

    // Randomized traffic with random backpressure and idle gaps
    ready_ctl = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
      send(rand_beat(), int'($urandom % 4), int'($urandom % 8), int'($signed(8'($urandom))));
    end
    ready_ctl = 0;
    drain();
    check("final_busy", 64'(busy), 64'd0);
`ifdef RELU_PIPE_ZERO_CNT_EN
    check("final_zero_cnt", 64'(zero_cnt), 64'(exp_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/relu_pipe.md
Name: relu_pipe

Overview:
- Parametrised, pipelined multi-lane activation unit; successor to the 8-bit combinational ReLU.
- Processes LANES signed WIDTH-bit elements per beat.
- Four modes: bypass, ReLU, leaky ReLU (arithmetic shift), clipped ReLU.
- Sits between the accumulator/requantiser output and the feature-map writeback buffer; valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, element width in bits, two's complement.
- LANES, 8, elements per beat.
- SHIFT_W, 3, width of the leaky-ReLU shift amount.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  2  0 bypass, 1 relu, 2 leaky, 3 clip; sampled with each accepted input beat.
- shift  input  SHIFT_W  leaky negative-slope shift; sampled with each accepted beat.
- clip_val  input  WIDTH  clip ceiling, signed; sampled with each accepted beat.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit accepts beat this cycle.
- in_data  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  LANES*WIDTH  results, same lane packing.
- busy  output  1  either pipeline stage holds a beat.

Behaviour:
- Two register stages, S1 then S2.
  - S1 captures in_data, mode, shift and clip_val.
  - S2 holds the computed result.
- Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - An input transfer happens when in_valid & in_ready.
- On adv:
  - S1 loads the input beat; its valid bit = in_valid.
  - S2 loads f(S1); its valid bit = S1 valid.
- When adv = 0, both stages hold data and valid unchanged.
- Latency: accepted beat appears on out_valid 2 cycles later when not stalled. Throughput 1 beat/cycle.
- Once asserted, out_valid stays high and out_data stays stable until out_ready.
- busy = S1 valid | S2 valid.
- Per-lane function f(x), x signed:
  - mode 0: x.
  - mode 1: x<0 ? 0 : x.
  - mode 2: x<0 ? (x >>> shift) : x.
    - Arithmetic shift, rounds toward -inf (-1 stays -1).
    - shift = 0 gives identity.
  - mode 3: x<0 ? 0 : (x > c ? c : x), where c = clip_val<0 ? 0 : clip_val.
    - Signed compare.
    - Negative clip_val makes all outputs 0.
- All lanes use the config captured with their beat. A config change between beats never affects beats already in flight.
- Reset (any time, including mid-stall): both valid bits = 0, out_data = 0, stage data = 0, in_ready = 1, busy = 0. In-flight beats are discarded.
- No overflow is possible: every result lies within [min(x,0), max(x,0)].

Optional Feature:
- Macro RELU_PIPE_ZERO_CNT_EN adds two ports:
  - zero_cnt  output  32: count of output lanes whose input was negative and whose result is 0 (modes 1 and 3, plus mode 3 with c = 0 and x = 0 excluded).
  - zero_cnt_clr  input  1: synchronous clear.
- zero_cnt increments by the popcount of such lanes on each output transfer (out_valid & out_ready).
- The counter saturates at 2^32-1.
- Clear has priority over an increment in the same cycle.
- Reset value is 0.
- Without the macro, neither port nor the counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset release, in_valid = 1, mode = 1, lanes {-128,-1,0,1,5,127,-7,64}, out_ready = 1 -> out_valid at cycle +2 with {0,0,0,1,5,127,0,64}; in_ready stays 1.
- mode = 2, shift = 2, lanes {-128,-1,-4,-5,3,…} -> {-32,-1,-1,-2,3,…}; shift = 0 -> output equals input.
- mode = 3, clip_val = 6, lanes {-3,0,5,6,7,100} -> {0,0,5,6,6,6}; clip_val = -5 -> all lanes 0.
- Stream 10 beats with mode alternating 0/1 per beat, out_ready low for 3 cycles mid-stream -> in_ready low while stalled, out_data held stable, every beat delivered once in order with its own mode, no loss or duplication.
- Assert reset_n = 0 while out_valid = 1 and stalled -> out_valid = 0, busy = 0, in_ready = 1 immediately (asynchronous); no stale beat emitted after release.
- With RELU_PIPE_ZERO_CNT_EN, mode 1, 4 beats each containing 3 negative lanes -> zero_cnt = 12; zero_cnt_clr pulsed together with a transfer -> zero_cnt = 0.
